audio_tone_tx: RTL
==================

Name: audio_tone_tx

Overview:
- Consumer end of the freqL/freqR tone interface driven by the game sound selector.
- Converts two 26-bit tone frequencies (Hz) into stereo square-wave 16-bit samples.
- Serialises the samples onto the board's I2S audio DAC pins: mclk, lrck, sck, sdin.
- Sits between game_sound and the top-level audio pins.

Parameters:
FS_INT, 195312, integer sample rate in Hz (100 MHz / 512); modulus of the phase accumulators
MAX_FREQ, 20000, tone frequency at or above which a channel is treated as silent
FADE_STEP, 256, amplitude change per sample when AUDIO_FADE_EN is defined

Ports:
clk  in  1  100 MHz system clock
rst  in  1  asynchronous, active-low reset
freqL  in  26  left tone frequency in Hz; 0 or >= MAX_FREQ = silent (mute value 50000000 falls here)
freqR  in  26  right tone frequency in Hz, same encoding
volume  in  3  amplitude select 0..7; amplitude = volume << 12
audio_mclk  out  1  master clock, clk/4
audio_lrck  out  1  word select, clk/512; 0 = left, 1 = right
audio_sck  out  1  bit clock, clk/16
audio_sdin  out  1  serial data, MSB first
sample_tick  out  1  one-clk pulse at each frame start (cnt == 0)

Behaviour:
- Reset: async on rst low, released synchronously to clk.
  - All outputs reset to 0.
  - cnt, both accumulators, both polarity bits and the latched frame word reset to 0.
- Timebase: a free-running 9-bit cnt increments every clk and wraps 511 -> 0.
  - audio_mclk = cnt[1], audio_sck = cnt[3], audio_lrck = cnt[8], all driven from registers.
- Frame: 512 clk long, 32 sck periods: 16 left bits, then 16 right bits.
- Frame start (cnt == 0):
  - sample_tick = 1 for that clk.
  - volume, freqL and freqR are sampled.
  - Per-channel tone update, then frame word {sampleL, sampleR} latched.
- Tone update per channel, phase accumulator acc (18 bits):
  - If freq == 0 or freq >= MAX_FREQ: acc <= 0, pol <= 0, sample = 0.
  - Otherwise: t = acc + 2*freq. If t >= FS_INT then acc <= t - FS_INT and pol toggles; else acc <= t.
  - Result: pol toggles 2*freq times per second, so the square wave runs at freq Hz.
  - Width: max t = 195311 + 39998 < 2^18; no overflow.
- Sample value (16-bit two's complement): amp = {1'b0, volume, 12'b0}.
  - pol = 1 gives +amp; pol = 0 gives -amp.
  - volume 0 gives 0 regardless of pol.
  - The new sample takes effect in the frame being latched (0 frame latency from the tone update).
- Serialisation: audio_sdin is registered each clk as frame_word[31 - cnt_prev[8:4]].
  - One clk lag, so data is stable 7 clk before each sck rising edge (cnt[3:0] == 8).
  - Bit 15 of each channel aligns with the lrck edge (left-justified, no I2S one-bit delay).
- Frequency change mid-frame: ignored until the next frame start; acc is retained, so the tone stays phase-continuous.
- Audible -> silent: acc and pol clear immediately at that frame start.
- Silent -> audible: the first sample is -amp (pol = 0).
- Reset mid-frame: all outputs drop to 0 asynchronously; after release cnt restarts at 0 and the first frame outputs zeros for both channels.

Optional Feature:
AUDIO_FADE_EN
- Defined:
  - Each channel keeps an amp_cur register, reset 0.
  - At each frame start, amp_cur steps toward the target amp (0 when silent) by FADE_STEP, clamped at the target.
  - The sample uses amp_cur.
  - On silent entry, acc and pol hold until amp_cur reaches 0, then clear.
- Undefined: amp_cur logic is absent; the sample uses amp directly, as above.

Test Plan:
- Reset: rst low mid-frame -> all outputs 0 within the same clk; after release, the first sample_tick comes 512 clk later (cnt wraps 511 -> 0), and the first frame sdin is all 0.
- Clocks: free run 2048 clk -> mclk period 4, sck period 16, lrck period 512; sample_tick spacing 512; lrck rises at cnt == 256.
- Tone: freqL = 9765, volume = 7 -> over 1000 frames pol toggles 100 ±1 times; samples alternate 16'h7000 / 16'h9000.
- Silence: freqR = 50000000 or 0 -> right 16 bits = 16'h0000 every frame. freqL = 440 concurrently -> left sample is ±16'h7000.
- Serial format: force sampleL = 16'h7000, sampleR = 16'h9000 -> sdin sampled on sck rising yields 0111000000000000 then 1001000000000000 across one lrck period.
- Fade (AUDIO_FADE_EN): volume 7, freq 0 -> 440 -> left amplitude ramps 0, 256, 512 … reaching 16'h7000 after 112 frames.

Source files
------------

// File: rtl/audio_tone_tx.sv
// Stereo square-wave tone generator driving a left-justified serial DAC; 512-clk frame, 16 left + 16 right bits.
// Optional amplitude ramp per frame when AUDIO_FADE_EN is defined.
module audio_tone_tx #(
  parameter int FS_INT   = 195312,
  parameter int MAX_FREQ = 20000
`ifdef AUDIO_FADE_EN
  ,
  parameter int FADE_STEP = 256
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [25:0] freqL,
  input  logic [25:0] freqR,
  input  logic [2:0]  volume,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        sample_tick
);

  logic [8:0]  cnt_q;
  logic        tick_q;
  logic        sdin_q;
  logic [31:0] frame_q;
  logic [31:0] frame_d;
  logic [17:0] acc_q [2];
  logic [17:0] acc_d [2];
  logic [1:0]  pol_q;
  logic [1:0]  pol_d;
  logic [25:0] freq [2];
  logic [15:0] sample [2];
  logic [15:0] amp;
  logic        frame_start;
`ifdef AUDIO_FADE_EN
  logic [15:0] amp_cur_q [2];
  logic [15:0] amp_cur_d [2];
`endif

  assign freq[0]     = freqL;
  assign freq[1]     = freqR;
  assign amp         = {1'b0, volume, 12'b0};
  // The tone update is registered on the 511 -> 0 edge so its result is live while cnt == 0.
  assign frame_start = (cnt_q == 9'd511);

  always_comb begin
    logic [18:0] t;
    logic        silent;
    logic [15:0] mag;
`ifdef AUDIO_FADE_EN
    logic [15:0] target;
`endif
    for (int ch = 0; ch < 2; ch++) begin
      silent     = (freq[ch] == 26'd0) || (freq[ch] >= 26'(MAX_FREQ));
      t          = 19'(acc_q[ch]) + {freq[ch][17:0], 1'b0};
      acc_d[ch]  = acc_q[ch];
      pol_d[ch]  = pol_q[ch];
      mag        = '0;
      sample[ch] = '0;
`ifdef AUDIO_FADE_EN
      target        = silent ? 16'd0 : amp;
      amp_cur_d[ch] = amp_cur_q[ch];
      if (amp_cur_q[ch] < target) begin
        amp_cur_d[ch] = ((target - amp_cur_q[ch]) > 16'(FADE_STEP)) ?
                        amp_cur_q[ch] + 16'(FADE_STEP) : target;
      end else if (amp_cur_q[ch] > target) begin
        amp_cur_d[ch] = ((amp_cur_q[ch] - target) > 16'(FADE_STEP)) ?
                        amp_cur_q[ch] - 16'(FADE_STEP) : target;
      end
      // Phase is frozen while fading out so the tail keeps its polarity.
      if (silent) begin
        if (amp_cur_d[ch] == 16'd0) begin
          acc_d[ch] = '0;
          pol_d[ch] = 1'b0;
        end
      end else if (t >= 19'(FS_INT)) begin
        acc_d[ch] = 18'(t - 19'(FS_INT));
        pol_d[ch] = ~pol_q[ch];
      end else begin
        acc_d[ch] = t[17:0];
      end
      mag = amp_cur_d[ch];
`else
      if (silent) begin
        acc_d[ch] = '0;
        pol_d[ch] = 1'b0;
      end else begin
        if (t >= 19'(FS_INT)) begin
          acc_d[ch] = 18'(t - 19'(FS_INT));
          pol_d[ch] = ~pol_q[ch];
        end else begin
          acc_d[ch] = t[17:0];
        end
        mag = amp;
      end
`endif
      sample[ch] = pol_d[ch] ? mag : -mag;
    end
    frame_d = {sample[0], sample[1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      sdin_q   <= 1'b0;
      frame_q  <= '0;
      pol_q    <= '0;
      acc_q[0] <= '0;
      acc_q[1] <= '0;
`ifdef AUDIO_FADE_EN
      amp_cur_q[0] <= '0;
      amp_cur_q[1] <= '0;
`endif
    end else begin
      cnt_q  <= cnt_q + 9'd1;
      tick_q <= frame_start;
      // ~cnt[8:4] == 31 - slot: MSB of the left word leads the frame.
      sdin_q <= frame_q[~cnt_q[8:4]];
      if (frame_start) begin
        frame_q  <= frame_d;
        pol_q    <= pol_d;
        acc_q[0] <= acc_d[0];
        acc_q[1] <= acc_d[1];
`ifdef AUDIO_FADE_EN
        amp_cur_q[0] <= amp_cur_d[0];
        amp_cur_q[1] <= amp_cur_d[1];
`endif
      end
    end
  end

  assign audio_mclk  = cnt_q[1];
  assign audio_sck   = cnt_q[3];
  assign audio_lrck  = cnt_q[8];
  assign audio_sdin  = sdin_q;
  assign sample_tick = tick_q;

endmodule
